// File: rtl/aes_frame_assembler_if.sv
//------------------------------------------------------------------------------
// Module   : aes_frame_assembler_if
// Purpose  : Bundles the byte-strobe input, the key/block outputs and the
//            error flags of the AES frame assembler into one connection.
//
// Signals  : rx_data     [7:0]   received byte, qualified by rx_valid
//            rx_valid            one-cycle strobe per received byte
//            key_out     [127:0] last committed key
//            key_valid           one-cycle pulse on key commit
//            blk_out     [127:0] plaintext block to the AES core
//            blk_valid           block available, held until accepted
//            blk_ready           AES core accepts blk_out
//            err_timeout         one-cycle pulse, partial frame discarded
//            err_header          one-cycle pulse, unknown header dropped
//            overrun             sticky, completed data frame dropped
//
// Modports : master - byte source / block consumer side
//            slave  - the frame assembler itself
//
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface aes_frame_assembler_if;

  logic [7:0]   rx_data;
  logic         rx_valid;
  logic [127:0] key_out;
  logic         key_valid;
  logic [127:0] blk_out;
  logic         blk_valid;
  logic         blk_ready;
  logic         err_timeout;
  logic         err_header;
  logic         overrun;

  modport master (
    output rx_data,
    output rx_valid,
    output blk_ready,
    input  key_out,
    input  key_valid,
    input  blk_out,
    input  blk_valid,
    input  err_timeout,
    input  err_header,
    input  overrun
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  blk_ready,
    output key_out,
    output key_valid,
    output blk_out,
    output blk_valid,
    output err_timeout,
    output err_header,
    output overrun
  );

endinterface : aes_frame_assembler_if

`default_nettype wire

// File: rtl/aes_frame_assembler.sv
//------------------------------------------------------------------------------
// Module   : aes_frame_assembler
// Purpose  : Framing stage behind the UART receiver. Recognises a one-byte
//            header ('K' = key frame, 'D' = data frame), packs the next 16
//            bytes MSB-first into a 128-bit word and commits it either as the
//            cipher key or as a plaintext block with a valid/ready handshake.
//            An inter-byte timeout throws away partial frames so the link
//            resynchronises after noise or a lost byte.
//
// Parameters : TIMEOUT_CLKS  idle clocks tolerated between payload bytes
//              HDR_KEY       header byte selecting a key frame
//              HDR_DATA      header byte selecting a data frame
//
// Ports    : clk   system clock, rising edge
//            rst_n asynchronous active-low reset
//            bus   aes_frame_assembler_if.slave (byte input, key/block
//                  outputs, error and overrun flags)
//
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module aes_frame_assembler #(
  parameter int         TIMEOUT_CLKS = 1_000_000,
  parameter logic [7:0] HDR_KEY      = 8'h4B,
  parameter logic [7:0] HDR_DATA     = 8'h44
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  aes_frame_assembler_if.slave   bus
);

  //--------------------------------------------------------------------------
  // Constants
  //--------------------------------------------------------------------------
  localparam int CNT_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

  // Timer value at which an idle payload state gives up on the frame.
  localparam logic [CNT_W-1:0] C_TIMER_LAST = CNT_W'(TIMEOUT_CLKS - 1);
  localparam logic [3:0]       C_LAST_BYTE  = 4'd15;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] KEY_PAY  = 2'd1;
  localparam logic [1:0] DATA_PAY = 2'd2;

  //--------------------------------------------------------------------------
  // State and datapath registers
  //--------------------------------------------------------------------------
  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [127:0]     r_asm;
  logic [3:0]       r_byte_cnt;
  logic [CNT_W-1:0] r_timer;

  logic [127:0]     r_key_out;
  logic             r_key_valid;
  logic [127:0]     r_blk_out;
  logic             r_blk_valid;
  logic             r_err_timeout;
  logic             r_err_header;
  logic             r_overrun;

  //--------------------------------------------------------------------------
  // Decode of the current cycle's events
  //--------------------------------------------------------------------------
  logic         w_in_payload;
  logic         w_byte_acc;
  logic         w_frame_done;
  logic [127:0] w_word;
  logic         w_expire;
  logic         w_key_commit;
  logic         w_data_commit;
  logic         w_data_drop;
  logic         w_blk_accept;
  logic         w_bad_header;

  assign w_in_payload = (r_state == KEY_PAY) || (r_state == DATA_PAY);
  assign w_byte_acc   = w_in_payload && bus.rx_valid;
  assign w_frame_done = w_byte_acc && (r_byte_cnt == C_LAST_BYTE);

  // Shifting left by a byte each time leaves the first payload byte in
  // [127:120] and the sixteenth in [7:0] once the frame is complete.
  assign w_word = {r_asm[119:0], bus.rx_data};

  // A byte arriving in the expiry cycle takes priority over the timeout.
  assign w_expire = w_in_payload && !bus.rx_valid && (r_timer == C_TIMER_LAST);

  assign w_key_commit = w_frame_done && (r_state == KEY_PAY);

  // A new block may be committed when the output slot is empty or is being
  // emptied in this very cycle; otherwise the completed frame is lost.
  assign w_data_commit = w_frame_done && (r_state == DATA_PAY) &&
                         (!r_blk_valid || bus.blk_ready);
  assign w_data_drop   = w_frame_done && (r_state == DATA_PAY) && !w_data_commit;

  assign w_blk_accept  = r_blk_valid && bus.blk_ready;

  assign w_bad_header  = (r_state == IDLE) && bus.rx_valid &&
                         (bus.rx_data != HDR_KEY) && (bus.rx_data != HDR_DATA);

  //--------------------------------------------------------------------------
  // Next-state logic
  //--------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == HDR_KEY) begin
            w_state_nxt = KEY_PAY;
          end else if (bus.rx_data == HDR_DATA) begin
            w_state_nxt = DATA_PAY;
          end
        end
      end
      KEY_PAY, DATA_PAY: begin
        // Header values inside a frame are just payload, so only frame
        // completion or expiry leave the payload states.
        if (w_frame_done || w_expire) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  //--------------------------------------------------------------------------
  // Byte counter and assembly register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_cnt <= 4'd0;
      r_asm      <= 128'd0;
    end else begin
      // Holding the counter at zero while idle means every payload state
      // starts counting from the first byte.
      if (!w_in_payload) begin
        r_byte_cnt <= 4'd0;
      end else if (bus.rx_valid) begin
        r_byte_cnt <= r_byte_cnt + 4'd1;
      end

      // Stale contents left by a discarded frame are simply shifted out by
      // the sixteen bytes of the next one.
      if (w_byte_acc) begin
        r_asm <= w_word;
      end
    end
  end

  //--------------------------------------------------------------------------
  // Inter-byte timeout
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else begin
      // Zero while idle, so entry to a payload state starts from zero.
      if (!w_in_payload || bus.rx_valid) begin
        r_timer <= '0;
      end else if (!w_expire) begin
        r_timer <= r_timer + 1'b1;
      end
    end
  end

  //--------------------------------------------------------------------------
  // Key output
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_out   <= 128'd0;
      r_key_valid <= 1'b0;
    end else begin
      r_key_valid <= w_key_commit;
      if (w_key_commit) begin
        r_key_out <= w_word;
      end
    end
  end

  //--------------------------------------------------------------------------
  // Block output with valid/ready handshake
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blk_out   <= 128'd0;
      r_blk_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      // A commit in the acceptance cycle keeps valid high with new data.
      if (w_data_commit) begin
        r_blk_out   <= w_word;
        r_blk_valid <= 1'b1;
      end else if (w_blk_accept) begin
        r_blk_valid <= 1'b0;
      end

      if (w_data_drop) begin
        r_overrun <= 1'b1;
      end
    end
  end

  //--------------------------------------------------------------------------
  // Error pulses
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_timeout <= 1'b0;
      r_err_header  <= 1'b0;
    end else begin
      r_err_timeout <= w_expire;
      r_err_header  <= w_bad_header;
    end
  end

  //--------------------------------------------------------------------------
  // Output drive
  //--------------------------------------------------------------------------
  assign bus.key_out     = r_key_out;
  assign bus.key_valid   = r_key_valid;
  assign bus.blk_out     = r_blk_out;
  assign bus.blk_valid   = r_blk_valid;
  assign bus.err_timeout = r_err_timeout;
  assign bus.err_header  = r_err_header;
  assign bus.overrun     = r_overrun;

endmodule : aes_frame_assembler

`default_nettype wire

// File: tb/tb_aes_frame_assembler.sv
//------------------------------------------------------------------------------
// Module   : tb_aes_frame_assembler
// Purpose  : Self-checking bench for aes_frame_assembler. Random payloads and
//            inter-byte gaps; expected words are built by placing each byte at
//            its position in the 128-bit word.
//
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_aes_frame_assembler;

  localparam int TO = 100;

  typedef logic [7:0] frame_t [16];

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   early_key;

  aes_frame_assembler_if bus ();

  aes_frame_assembler #(
    .TIMEOUT_CLKS (TO),
    .HDR_KEY      (8'h4B),
    .HDR_DATA     (8'h44)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: byte i of the frame occupies bits [127-8i -: 8].
  function automatic logic [127:0] frame_word(input frame_t f);
    logic [127:0] w;
    w = '0;
    for (int i = 0; i < 16; i++) w[127 - 8*i -: 8] = f[i];
    return w;
  endfunction

  task automatic rand_frame(output frame_t f);
    for (int i = 0; i < 16; i++) begin
      f[i] = 8'($urandom);
      // Sprinkle header values into payloads; they must be taken as data.
      if ($urandom_range(3, 0) == 0) f[i] = ($urandom_range(1, 0) == 1) ? 8'h4B : 8'h44;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Presents one byte for exactly one rising edge; returns at the following
  // falling edge, where the outputs of that edge are visible.
  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
  endtask

  task automatic send_payload(input frame_t f, input int max_gap, input bit ready_on_last);
    for (int i = 0; i < 16; i++) begin
      if (i > 0 && max_gap > 0) idle(int'($urandom_range(max_gap, 0)));
      if (i == 15 && ready_on_last) bus.blk_ready = 1'b1;
      send_byte(f[i]);
      if (i < 15 && bus.key_valid) early_key++;
    end
  endtask

  //--------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    checks++; if (bus.key_out !== 128'd0) begin failures++; $display("FAIL reset_key_out got=%h exp=0", bus.key_out); end
    checks++; if (bus.blk_out !== 128'd0) begin failures++; $display("FAIL reset_blk_out got=%h exp=0", bus.blk_out); end
    checks++; if (bus.key_valid !== 1'b0) begin failures++; $display("FAIL reset_key_valid got=%b exp=0", bus.key_valid); end
    checks++; if (bus.blk_valid !== 1'b0) begin failures++; $display("FAIL reset_blk_valid got=%b exp=0", bus.blk_valid); end
    checks++; if (bus.err_timeout !== 1'b0) begin failures++; $display("FAIL reset_err_timeout got=%b exp=0", bus.err_timeout); end
    checks++; if (bus.err_header !== 1'b0) begin failures++; $display("FAIL reset_err_header got=%b exp=0", bus.err_header); end
    checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", bus.overrun); end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_key_frame();
    frame_t f;
    for (int i = 0; i < 16; i++) f[i] = 8'(i);
    early_key = 0;
    send_byte(8'h4B);
    send_payload(f, 3, 1'b0);
    checks++; if (bus.key_valid !== 1'b1) begin failures++; $display("FAIL key_valid got=%b exp=1", bus.key_valid); end
    checks++; if (bus.key_out !== 128'h000102030405060708090A0B0C0D0E0F) begin failures++; $display("FAIL key_out got=%h exp=000102030405060708090a0b0c0d0e0f", bus.key_out); end
    checks++; if (bus.blk_valid !== 1'b0) begin failures++; $display("FAIL key_blk_valid got=%b exp=0", bus.blk_valid); end
    idle(1);
    checks++; if (bus.key_valid !== 1'b0) begin failures++; $display("FAIL key_valid_pulse got=%b exp=0", bus.key_valid); end
    for (int n = 0; n < 3; n++) begin
      rand_frame(f);
      idle(int'($urandom_range(4, 0)));
      send_byte(8'h4B);
      send_payload(f, 20, 1'b0);
      checks++; if (bus.key_valid !== 1'b1) begin failures++; $display("FAIL rand_key_valid got=%b exp=1", bus.key_valid); end
      checks++; if (bus.key_out !== frame_word(f)) begin failures++; $display("FAIL rand_key_out got=%h exp=%h", bus.key_out, frame_word(f)); end
      idle(1);
    end
    checks++; if (early_key !== 0) begin failures++; $display("FAIL key_early got=%0d exp=0", early_key); end
  endtask

  task automatic test_data_ready();
    frame_t f;
    for (int i = 0; i < 16; i++) f[i] = 8'(8'h10 + i);
    bus.blk_ready = 1'b1;
    send_byte(8'h44);
    send_payload(f, 0, 1'b0);
    checks++; if (bus.blk_valid !== 1'b1) begin failures++; $display("FAIL data_blk_valid got=%b exp=1", bus.blk_valid); end
    checks++; if (bus.blk_out !== 128'h101112131415161718191A1B1C1D1E1F) begin failures++; $display("FAIL data_blk_out got=%h exp=101112131415161718191a1b1c1d1e1f", bus.blk_out); end
    checks++; if (bus.key_valid !== 1'b0) begin failures++; $display("FAIL data_key_valid got=%b exp=0", bus.key_valid); end
    idle(1);
    checks++; if (bus.blk_valid !== 1'b0) begin failures++; $display("FAIL data_blk_valid_pulse got=%b exp=0", bus.blk_valid); end
    bus.blk_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    frame_t a, b;
    rand_frame(a);
    rand_frame(b);
    bus.blk_ready = 1'b0;
    send_byte(8'h44);
    send_payload(a, 5, 1'b0);
    checks++; if (bus.blk_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_a got=%b exp=1", bus.blk_valid); end
    checks++; if (bus.blk_out !== frame_word(a)) begin failures++; $display("FAIL bp_out_a got=%h exp=%h", bus.blk_out, frame_word(a)); end
    checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL bp_overrun_a got=%b exp=0", bus.overrun); end
    send_byte(8'h44);
    send_payload(b, 5, 1'b0);
    checks++; if (bus.blk_out !== frame_word(a)) begin failures++; $display("FAIL bp_out_held got=%h exp=%h", bus.blk_out, frame_word(a)); end
    checks++; if (bus.blk_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_held got=%b exp=1", bus.blk_valid); end
    checks++; if (bus.overrun !== 1'b1) begin failures++; $display("FAIL bp_overrun got=%b exp=1", bus.overrun); end
    idle(3);
    checks++; if (bus.overrun !== 1'b1) begin failures++; $display("FAIL bp_overrun_sticky got=%b exp=1", bus.overrun); end
    bus.blk_ready = 1'b1;
    idle(1);
    checks++; if (bus.blk_valid !== 1'b0) begin failures++; $display("FAIL bp_valid_fall got=%b exp=0", bus.blk_valid); end
    bus.blk_ready = 1'b0;
  endtask

  task automatic test_reset_midframe();
    frame_t f;
    rand_frame(f);
    send_byte(8'h4B);
    for (int i = 0; i < 8; i++) send_byte(8'($urandom));
    rst_n = 1'b0;
    #1;
    checks++; if (bus.key_out !== 128'd0) begin failures++; $display("FAIL rst_key_out got=%h exp=0", bus.key_out); end
    checks++; if (bus.blk_out !== 128'd0) begin failures++; $display("FAIL rst_blk_out got=%h exp=0", bus.blk_out); end
    checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL rst_overrun got=%b exp=0", bus.overrun); end
    idle(2);
    rst_n = 1'b1;
    idle(1);
    send_byte(8'h4B);
    send_payload(f, 4, 1'b0);
    checks++; if (bus.key_valid !== 1'b1) begin failures++; $display("FAIL rst_next_key_valid got=%b exp=1", bus.key_valid); end
    checks++; if (bus.key_out !== frame_word(f)) begin failures++; $display("FAIL rst_next_key_out got=%h exp=%h", bus.key_out, frame_word(f)); end
    idle(1);
  endtask

  task automatic test_accept_commit();
    frame_t a, b;
    rand_frame(a);
    rand_frame(b);
    bus.blk_ready = 1'b0;
    send_byte(8'h44);
    send_payload(a, 3, 1'b0);
    checks++; if (bus.blk_out !== frame_word(a)) begin failures++; $display("FAIL ac_out_a got=%h exp=%h", bus.blk_out, frame_word(a)); end
    send_byte(8'h44);
    send_payload(b, 3, 1'b1);
    checks++; if (bus.blk_valid !== 1'b1) begin failures++; $display("FAIL ac_valid got=%b exp=1", bus.blk_valid); end
    checks++; if (bus.blk_out !== frame_word(b)) begin failures++; $display("FAIL ac_out_b got=%h exp=%h", bus.blk_out, frame_word(b)); end
    checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL ac_overrun got=%b exp=0", bus.overrun); end
    idle(1);
    checks++; if (bus.blk_valid !== 1'b0) begin failures++; $display("FAIL ac_valid_fall got=%b exp=0", bus.blk_valid); end
    bus.blk_ready = 1'b0;
  endtask

  task automatic test_timeout();
    frame_t f;
    int pulses, first;
    rand_frame(f);
    pulses = 0;
    first  = 0;
    send_byte(8'h44);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom));
    for (int k = 1; k <= TO + 5; k++) begin
      @(negedge clk);
      if (bus.err_timeout) begin
        pulses++;
        if (first == 0) first = k;
      end
    end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL to_pulses got=%0d exp=1", pulses); end
    checks++; if (first !== TO) begin failures++; $display("FAIL to_cycle got=%0d exp=%0d", first, TO); end
    bus.blk_ready = 1'b1;
    send_byte(8'h44);
    send_payload(f, 6, 1'b0);
    checks++; if (bus.blk_valid !== 1'b1) begin failures++; $display("FAIL to_next_valid got=%b exp=1", bus.blk_valid); end
    checks++; if (bus.blk_out !== frame_word(f)) begin failures++; $display("FAIL to_next_out got=%h exp=%h", bus.blk_out, frame_word(f)); end
    idle(1);
  endtask

  task automatic test_timeout_boundary();
    frame_t f;
    int pulses;
    rand_frame(f);
    pulses = 0;
    bus.blk_ready = 1'b1;
    send_byte(8'h44);
    for (int i = 0; i < 5; i++) send_byte(f[i]);
    for (int k = 1; k < TO; k++) begin
      @(negedge clk);
      if (bus.err_timeout) pulses++;
    end
    for (int i = 5; i < 16; i++) begin
      send_byte(f[i]);
      if (bus.err_timeout) pulses++;
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL tb_boundary_pulses got=%0d exp=0", pulses); end
    checks++; if (bus.blk_valid !== 1'b1) begin failures++; $display("FAIL tb_boundary_valid got=%b exp=1", bus.blk_valid); end
    checks++; if (bus.blk_out !== frame_word(f)) begin failures++; $display("FAIL tb_boundary_out got=%h exp=%h", bus.blk_out, frame_word(f)); end
    idle(1);
    bus.blk_ready = 1'b0;
  endtask

  task automatic test_bad_header();
    logic [7:0] b;
    frame_t f;
    for (int n = 0; n < 4; n++) begin
      if (n == 0) b = 8'h55;
      else begin
        do b = 8'($urandom); while (b == 8'h4B || b == 8'h44);
      end
      send_byte(b);
      checks++; if (bus.err_header !== 1'b1) begin failures++; $display("FAIL hdr_pulse byte=%h got=%b exp=1", b, bus.err_header); end
      idle(1);
      checks++; if (bus.err_header !== 1'b0) begin failures++; $display("FAIL hdr_pulse_end byte=%h got=%b exp=0", b, bus.err_header); end
    end
    rand_frame(f);
    send_byte(8'h4B);
    checks++; if (bus.err_header !== 1'b0) begin failures++; $display("FAIL hdr_good got=%b exp=0", bus.err_header); end
    send_payload(f, 2, 1'b0);
    checks++; if (bus.key_out !== frame_word(f)) begin failures++; $display("FAIL hdr_after_key got=%h exp=%h", bus.key_out, frame_word(f)); end
    idle(1);
  endtask

  task automatic test_back_to_back();
    frame_t f1, f2, f3;
    rand_frame(f1);
    rand_frame(f2);
    rand_frame(f3);
    bus.blk_ready = 1'b1;
    send_byte(8'h4B);
    send_payload(f1, 0, 1'b0);
    checks++; if (bus.key_out !== frame_word(f1) || bus.key_valid !== 1'b1) begin failures++; $display("FAIL b2b_key1 got=%h/%b exp=%h/1", bus.key_out, bus.key_valid, frame_word(f1)); end
    send_byte(8'h44);
    send_payload(f2, 0, 1'b0);
    checks++; if (bus.blk_out !== frame_word(f2) || bus.blk_valid !== 1'b1) begin failures++; $display("FAIL b2b_blk got=%h/%b exp=%h/1", bus.blk_out, bus.blk_valid, frame_word(f2)); end
    send_byte(8'h4B);
    send_payload(f3, 0, 1'b0);
    checks++; if (bus.key_out !== frame_word(f3) || bus.key_valid !== 1'b1) begin failures++; $display("FAIL b2b_key2 got=%h/%b exp=%h/1", bus.key_out, bus.key_valid, frame_word(f3)); end
    idle(1);
    bus.blk_ready = 1'b0;
  endtask

  //--------------------------------------------------------------------------
  initial begin
    checks        = 0;
    failures      = 0;
    early_key     = 0;
    rst_n         = 1'b0;
    bus.rx_data   = 8'd0;
    bus.rx_valid  = 1'b0;
    bus.blk_ready = 1'b0;

    test_reset();
    test_key_frame();
    test_data_ready();
    test_backpressure();
    test_reset_midframe();
    test_accept_commit();
    test_timeout();
    test_timeout_boundary();
    test_bad_header();
    test_back_to_back();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500_000;
    failures++;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_aes_frame_assembler

`default_nettype wire

// File: doc/aes_frame_assembler.md
# aes_frame_assembler

Framing stage directly downstream of the UART receiver in the AES-128 datapath. Consumes the one-cycle byte strobes produced by the receiver, recognises a one-byte header, packs the following 16 bytes into a 128-bit word and delivers it either as a new cipher key or as a plaintext block for the AES core. An inter-byte timeout discards partial frames so the link resynchronises after line noise or a dropped byte.

## Interface
- TIMEOUT_CLKS, 1_000_000: idle clocks allowed between payload bytes before the frame is discarded (10 ms at 100 MHz, about 9.6 byte times at 9600 baud).
- HDR_KEY, 8'h4B: header byte ('K') selecting a key frame.
- HDR_DATA, 8'h44: header byte ('D') selecting a data frame.
- clk  in  1  system clock, 100 MHz; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte; valid only when rx_valid is high.
- rx_valid  in  1  one-cycle strobe per received byte.
- key_out  out  128  last committed key.
- key_valid  out  1  one-cycle pulse when key_out is updated.
- blk_out  out  128  plaintext block to the AES core.
- blk_valid  out  1  block available; held until accepted.
- blk_ready  in  1  AES core accepts blk_out when blk_valid and blk_ready are both high.
- err_timeout  out  1  one-cycle pulse when a partial frame is discarded.
- err_header  out  1  one-cycle pulse when an unrecognised header byte is dropped.
- overrun  out  1  sticky; set when a completed data frame is dropped; cleared only by reset.

## Operation
- States: IDLE, KEY_PAY, DATA_PAY.
- IDLE: on rx_valid, a byte equal to HDR_KEY goes to KEY_PAY, one equal to HDR_DATA goes to DATA_PAY, and any other byte pulses err_header and stays in IDLE. The byte counter clears on entry to either payload state.
- KEY_PAY / DATA_PAY: each rx_valid shifts rx_data into the 128-bit assembly register. The first payload byte lands in bits [127:120] and the 16th in [7:0]. The 4-bit byte counter increments, and the 16th byte (counter = 15) completes the frame.
- Key commit: on frame completion, key_out is loaded with the assembled word, key_valid pulses and the block returns to IDLE. Key commits are independent of the blk handshake.
- Data commit: when blk_valid is low, or blk_ready is high in the same cycle, blk_out is loaded, blk_valid is set and the block returns to IDLE. Otherwise the completed frame is dropped, overrun is set, blk_out is unchanged and the block returns to IDLE.
- Handshake: blk_valid falls in the cycle after blk_ready is sampled high, unless a data commit occurs in that same cycle, in which case blk_valid stays high with the new blk_out. blk_out is stable while blk_valid is high and not accepted.
- Timeout: the counter runs only in payload states, reloads to 0 on every rx_valid and on entry to a payload state. On reaching TIMEOUT_CLKS-1 it pulses err_timeout, returns the block to IDLE, and discards the assembly register contents without clearing them. Counter width is $clog2(TIMEOUT_CLKS).
- Simultaneous events: rx_valid in the expiry cycle wins; the byte is accepted and no timeout occurs. A header byte arriving mid-payload is treated as payload data.
- Reset asserted mid-frame: the partial frame is lost, the block returns to IDLE and all outputs are cleared.

## Timing
- Reset values: key_out = 0, blk_out = 0, key_valid = 0, blk_valid = 0, err_timeout = 0, err_header = 0, overrun = 0, state IDLE.
- All outputs are registered.
- Latency: a 16th payload byte strobed at edge N produces key_valid or blk_valid high and the new data visible after edge N+1.
- err_header and err_timeout are asserted for exactly one cycle after the triggering edge.
- Back-to-back rx_valid on consecutive cycles is accepted; the block sustains one byte per clock.

## Test plan
- Key frame: 0x4B then bytes 0x00..0x0F -> one key_valid pulse; key_out = 128'h000102030405060708090A0B0C0D0E0F; blk_valid stays 0.
- Data frame with blk_ready held 1: 0x44 then 0x10..0x1F -> blk_valid high for exactly 1 cycle; blk_out = 128'h101112131415161718191A1B1C1D1E1F.
- Back-pressure: blk_ready = 0, send two complete data frames -> first block held stable, overrun = 1, second frame lost. Then raise blk_ready -> blk_valid falls the next cycle.
- Accept and commit together: blk_ready rises in the same cycle the 16th byte of a second frame commits -> blk_valid stays high, blk_out becomes the second block, overrun = 0.
- Timeout: with TIMEOUT_CLKS = 100, send 0x44 and 5 bytes, then stay silent -> err_timeout pulses 100 clocks after the last byte and the state is IDLE. A following full 'D' frame is assembled correctly. A byte at exactly clock 99 after the last byte prevents the timeout.
- Bad header and reset: byte 0x55 in IDLE -> single err_header pulse. Assert rst_n low after the 8th byte of a key frame -> all outputs 0, and the next frame is assembled correctly.
